// File: rtl/iir_out_buffer.sv
// -----------------------------------------------------------------------------
// iir_out_buffer
//
// Output buffer for the IIR filter. It holds the filtered samples in a
// show-ahead circular FIFO until a downstream consumer takes them. The head
// entry is always visible on dout.
//
// Optional feature (macro IIR_BUF_DECIM2_EN):
//   When the macro is defined, a 2:1 averaging decimator sits in front of the
//   FIFO. Each pair of input samples becomes one stored value,
//   (a + b) >> 1. The sum is DATA_W+1 bits wide and the result is truncated.
//   When the macro is not defined, every valid input sample is pushed.
//
// Parameters:
//   DATA_W     width of the samples, unsigned
//   DEPTH      number of FIFO entries, a power of two and at least 2
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   y_in       sample from the iir_filter y_out port
//   y_valid    y_in carries a new sample this cycle
//   dout       head-of-FIFO sample; 0 when the FIFO is empty
//   dout_valid dout holds a valid entry (count != 0)
//   dout_ready consumer accepts dout this cycle
//   count      number of stored entries, 0..DEPTH
//   overflow   sticky flag, set when a sample was dropped on a full FIFO
// -----------------------------------------------------------------------------
module iir_out_buffer #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          y_in,
  input  logic                       y_valid,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  logic              overflow_q;

  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              pop;
  logic              do_push;

`ifdef IIR_BUF_DECIM2_EN
  typedef enum logic {PH0, PH1} phase_t;

  phase_t            phase_q;
  phase_t            phase_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;
  logic [DATA_W:0]   pair_sum;

  // Widen by one bit so the sum of two full-scale samples cannot wrap
  // before the halving.
  assign pair_sum = {1'b0, hold_q} + {1'b0, y_in};

  // The first sample of a pair is parked in the hold register. The second
  // one produces the averaged push request. A request that gets dropped
  // because the FIFO is full still completes the pair, so the FSM returns
  // to PH0 in either case.
  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    push_req  = 1'b0;
    push_data = DATA_W'(pair_sum >> 1);
    case (phase_q)
      PH0: begin
        if (y_valid) begin
          hold_d  = y_in;
          phase_d = PH1;
        end
      end
      PH1: begin
        if (y_valid) begin
          push_req = 1'b1;
          phase_d  = PH0;
        end
      end
      default: phase_d = PH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end
`else
  assign push_req  = y_valid;
  assign push_data = y_in;
`endif

  assign full    = (count_q == CNT_FULL);
  assign pop     = (count_q != '0) && dout_ready;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_req && (!full || pop);

  // The storage array has no reset. Stale contents are unreachable once the
  // pointers and the count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (push_req && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // The outputs depend only on registered state. There is no bypass from
  // y_in.
  assign dout_valid = (count_q != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_iir_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_iir_out_buffer
//
// Directed, self-checking bench for iir_out_buffer with DATA_W = 7 and
// DEPTH = 8. The expected values are worked out by hand in each task.
// Define IIR_BUF_DECIM2_EN to run the decimator scenario in place of the
// plain-FIFO scenarios.
// -----------------------------------------------------------------------------
module tb_iir_out_buffer;

  localparam int DATA_W = 7;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] y_in;
  logic              y_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [3:0]        count;
  logic              overflow;

  int n_checks;
  int n_pass;

  iir_out_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge. Inputs change
  // and outputs are sampled at that point, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    y_valid    = 1'b0;
    y_in       = '0;
    dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    y_valid    = 1'b1;
    y_in       = 7'd55;
    dout_ready = 1'b1;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    n_checks++;
    if (count !== 4'd0) $display("[TB] FAIL reset_count got %0d expected 0", count);
    else n_pass++;
    n_checks++;
    if (dout_valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b expected 0", dout_valid);
    else n_pass++;
    n_checks++;
    if (dout !== 7'd0) $display("[TB] FAIL reset_dout got %0d expected 0", dout);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %0b expected 0", overflow);
    else n_pass++;
  endtask

`ifndef IIR_BUF_DECIM2_EN
  task automatic push_one(input logic [DATA_W-1:0] v);
    y_in       = v;
    y_valid    = 1'b1;
    dout_ready = 1'b0;
    step();
    y_valid = 1'b0;
  endtask

  task automatic test_push_sequence();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 7'd3;
    vals[1] = 7'd1;
    vals[2] = 7'd2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_one(vals[i]);
      n_checks++;
      if (count !== 4'(i + 1)) $display("[TB] FAIL seq_count[%0d] got %0d expected %0d", i, count, i + 1);
      else n_pass++;
      n_checks++;
      if (dout !== 7'd3 || dout_valid !== 1'b1)
        $display("[TB] FAIL seq_head[%0d] got %0d/%0b expected 3/1", i, dout, dout_valid);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(7'(i));
    push_one(7'd9);
    n_checks++;
    if (count !== 4'd8) $display("[TB] FAIL ovf_count got %0d expected 8", count);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got %0b expected 1", overflow);
    else n_pass++;
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dout !== 7'(i) || dout_valid !== 1'b1)
        $display("[TB] FAIL ovf_drain[%0d] got %0d/%0b expected %0d/1", i, dout, dout_valid, i);
      else n_pass++;
      step();
    end
    dout_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0 || dout !== 7'd0)
      $display("[TB] FAIL ovf_empty got count=%0d valid=%0b dout=%0d expected 0/0/0", count, dout_valid, dout);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky got %0b expected 1", overflow);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] exp_q [8];
    do_reset();
    for (int i = 0; i < 8; i++) push_one(7'(i + 1));
    y_in       = 7'd5;
    y_valid    = 1'b1;
    dout_ready = 1'b1;
    step();
    y_valid = 1'b0;
    n_checks++;
    if (count !== 4'd8) $display("[TB] FAIL full_pp_count got %0d expected 8", count);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL full_pp_overflow got %0b expected 0", overflow);
    else n_pass++;
    for (int i = 0; i < 7; i++) exp_q[i] = 7'(i + 2);
    exp_q[7] = 7'd5;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dout !== exp_q[i]) $display("[TB] FAIL full_pp_drain[%0d] got %0d expected %0d", i, dout, exp_q[i]);
      else n_pass++;
      step();
    end
    dout_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0) $display("[TB] FAIL full_pp_empty got %0d expected 0", count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    // dout_ready while empty has no effect.
    dout_ready = 1'b1;
    step();
    n_checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0)
      $display("[TB] FAIL empty_pop got count=%0d valid=%0b expected 0/0", count, dout_valid);
    else n_pass++;
    dout_ready = 1'b0;
    push_one(7'd10);
    push_one(7'd20);
    // Simultaneous push and pop at mid fill.
    y_in       = 7'd30;
    y_valid    = 1'b1;
    dout_ready = 1'b1;
    step();
    n_checks++;
    if (count !== 4'd2 || dout !== 7'd20)
      $display("[TB] FAIL b2b_mid got count=%0d dout=%0d expected 2/20", count, dout);
    else n_pass++;
    y_valid = 1'b0;
    step();
    n_checks++;
    if (count !== 4'd1 || dout !== 7'd30)
      $display("[TB] FAIL b2b_tail got count=%0d dout=%0d expected 1/30", count, dout);
    else n_pass++;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(7'(i + 40));
    push_one(7'd99);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    dout_ready = 1'b0;
    n_checks++;
    if (count !== 4'd4 || overflow !== 1'b1)
      $display("[TB] FAIL rmid_pre got count=%0d ovf=%0b expected 4/1", count, overflow);
    else n_pass++;
    rst        = 1'b1;
    y_in       = 7'd7;
    y_valid    = 1'b1;
    dout_ready = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    n_checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0 || dout !== 7'd0 || overflow !== 1'b0)
      $display("[TB] FAIL rmid_post got count=%0d valid=%0b dout=%0d ovf=%0b expected 0/0/0/0",
               count, dout_valid, dout, overflow);
    else n_pass++;
  endtask
`else
  task automatic feed(input logic [DATA_W-1:0] v);
    y_in    = v;
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
  endtask

  task automatic test_decim();
    do_reset();
    feed(7'd3);
    n_checks++;
    if (count !== 4'd0) $display("[TB] FAIL dec_half got %0d expected 0", count);
    else n_pass++;
    feed(7'd6);
    n_checks++;
    if (count !== 4'd1 || dout !== 7'd4)
      $display("[TB] FAIL dec_first got count=%0d dout=%0d expected 1/4", count, dout);
    else n_pass++;
    feed(7'd127);
    feed(7'd127);
    n_checks++;
    if (count !== 4'd2) $display("[TB] FAIL dec_count got %0d expected 2", count);
    else n_pass++;
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    n_checks++;
    if (dout !== 7'd127 || count !== 4'd1)
      $display("[TB] FAIL dec_second got count=%0d dout=%0d expected 1/127", count, dout);
    else n_pass++;
    feed(7'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (count !== 4'd0) $display("[TB] FAIL dec_rst_count got %0d expected 0", count);
    else n_pass++;
    // A leftover half-pair would make this single sample complete a pair.
    feed(7'd20);
    n_checks++;
    if (count !== 4'd0) $display("[TB] FAIL dec_rst_phase got %0d expected 0", count);
    else n_pass++;
    feed(7'd40);
    n_checks++;
    if (dout !== 7'd30 || count !== 4'd1)
      $display("[TB] FAIL dec_after_rst got count=%0d dout=%0d expected 1/30", count, dout);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    idle_inputs();
    step();
    test_reset();
`ifndef IIR_BUF_DECIM2_EN
    test_push_sequence();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
`else
    test_decim();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iir_out_buffer.md
IIR_OUT_BUFFER -- requirements
Module: iir_out_buffer

Interface
REQ-001 Parameter DATA_W, default 7, width of filter output samples carried by the buffer.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 y_in  input  DATA_W  filtered sample from iir_filter y_out, unsigned.
REQ-006 y_valid  input  1  y_in holds a new sample this cycle.
REQ-007 dout  output  DATA_W  head-of-FIFO sample (show-ahead).
REQ-008 dout_valid  output  1  dout holds a valid entry.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag, a sample was dropped because the FIFO was full.

Function
REQ-012 Circular FIFO: write and read pointers log2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-013 dout_valid SHALL be 1 exactly when count != 0; dout SHALL be 0 when count == 0.
REQ-014 Pop SHALL occur when dout_valid && dout_ready: read pointer advances, count decrements.
REQ-015 Push SHALL occur on a push request (REQ-020/REQ-025) when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop SHALL leave count unchanged at any fill level, including full.
REQ-017 Push request while full with no pop SHALL drop the sample, leave FIFO contents and count unchanged, and set overflow to 1.
REQ-018 No bypass: a sample pushed into an empty FIFO SHALL appear on dout, with dout_valid = 1, one cycle after the push edge.
REQ-019 dout_ready while empty SHALL have no effect.
REQ-020 Without decimation (REQ-026), each cycle with y_valid = 1 SHALL be a push request of y_in.
REQ-021 overflow SHALL remain 1 until rst; it SHALL NOT affect normal push and pop.
REQ-022 dout, dout_valid and count SHALL be registered or derived only from registered state, with no combinational path from y_in or y_valid.

Reset
REQ-023 On rst = 1 at a clock edge: pointers = 0, count = 0, overflow = 0, dout = 0, dout_valid = 0, decimation phase = PH0, hold register = 0.
REQ-024 Reset mid-operation SHALL discard all stored entries and any half-formed decimation pair; y_valid and dout_ready SHALL be ignored in reset cycles.

Configuration
REQ-025 Macro IIR_BUF_DECIM2_EN defined: 2:1 averaging decimator ahead of the FIFO, using a two-state FSM (PH0, PH1).
- PH0 with y_valid: store y_in in the hold register, go to PH1, no push request.
- PH1 with y_valid: push request of (hold + y_in) >> 1, sum DATA_W+1 bits, truncated; go to PH0.
- No y_valid: state unchanged.
- A full-FIFO drop of the averaged value SHALL follow REQ-017 and return the FSM to PH0.
REQ-026 Macro IIR_BUF_DECIM2_EN undefined: no FSM and no hold register; REQ-020 applies.

Verification
REQ-027 Reset, then push 3, 1, 2 on consecutive cycles with dout_ready = 0 -> count 1, 2, 3; dout = 3, dout_valid = 1 from the cycle after the first push.
REQ-028 Fill 8 entries 0..7, then one more y_valid with y_in = 9 and no pop -> count stays 8, overflow = 1; drain yields 0..7 in order and 9 is absent.
REQ-029 Full FIFO, y_valid with y_in = 5 and dout_ready = 1 in the same cycle -> count stays 8, head advances, 5 is read out last; pointers wrap correctly.
REQ-030 Assert rst mid-stream with 4 entries and overflow = 1 -> next cycle count = 0, dout_valid = 0, dout = 0, overflow = 0.
REQ-031 With IIR_BUF_DECIM2_EN: y_in 3, 6, 127, 127 -> entries 4, 127; odd trailing sample 10 followed by rst -> no entry pushed.
